// File: rtl/pc_unit_ras_if.sv
// Fetch-side bundle for the PC unit: control/redirect inputs toward the PC,
// PC and return-address-stack status back toward the fetch logic.
interface pc_unit_ras_if #(
    parameter int ADDR_W = 32
);
    logic              stall;
    logic              exc_valid;
    logic              redirect_valid;
    logic [ADDR_W-3:0] redirect_target;
    logic              ret_valid;
    logic              call_valid;
    logic [ADDR_W-3:0] call_link;
    logic [ADDR_W-1:0] pc_result;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic              ras_full;
    logic              ret_miss;
    logic              ras_overflow;

    modport master (
        output stall, exc_valid, redirect_valid, redirect_target,
               ret_valid, call_valid, call_link,
        input  pc_result, pc_plus4, ras_top, ras_empty, ras_full,
               ret_miss, ras_overflow
    );

    modport slave (
        input  stall, exc_valid, redirect_valid, redirect_target,
               ret_valid, call_valid, call_link,
        output pc_result, pc_plus4, ras_top, ras_empty, ras_full,
               ret_miss, ras_overflow
    );
endinterface

// File: rtl/pc_unit_ras.sv
// Fetch-stage program counter with prioritised next-PC selection and a
// circular return-address stack used to predict jr $ra targets.
module pc_unit_ras #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] EXC_VEC   = 32'h0000_0080,
    parameter int                RAS_DEPTH = 4,
    parameter int                PTR_W     = 2
) (
    input logic         clk,
    input logic         reset,
    pc_unit_ras_if.slave bus
);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-3:0] pc;
    logic [ADDR_W-3:0] entries [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [CNT_W-1:0]  count;
    logic              ret_miss_q;
    logic              overflow_q;

    logic              empty;
    logic              full;
    logic              pop_ok;
    logic              pop;
    logic              push;
    logic              miss;
    logic [PTR_W-1:0]  ptr_inc;
    logic [PTR_W-1:0]  ptr_dec;

    always_comb begin
        empty   = (count == '0);
        full    = (count == CNT_W'(RAS_DEPTH));
        // A return may only consume the stack when nothing of higher priority wins.
        pop_ok  = bus.ret_valid && !bus.exc_valid && !bus.redirect_valid && !bus.stall;
        pop     = pop_ok && !empty;
        miss    = pop_ok && empty;
        // A jal redirect pushes its link even while the pipe is stalled.
        push    = bus.call_valid && !bus.exc_valid && (!bus.stall || bus.redirect_valid);
        ptr_inc = ptr + PTR_W'(1);
        ptr_dec = ptr - PTR_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_VEC[ADDR_W-1:2];
            ptr        <= '0;
            count      <= '0;
            ret_miss_q <= 1'b0;
            overflow_q <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            ret_miss_q <= miss;
            overflow_q <= push && !pop && full;

            if (bus.exc_valid) begin
                pc <= EXC_VEC[ADDR_W-1:2];
            end else if (bus.redirect_valid) begin
                pc <= bus.redirect_target;
            end else if (!bus.stall) begin
                pc <= pop ? entries[ptr] : pc + 1'b1;
            end

            if (bus.exc_valid) begin
                ptr   <= '0;
                count <= '0;
            end else if (push && pop) begin
                entries[ptr] <= bus.call_link;
            end else if (push) begin
                // When full the increment lands on the oldest entry and overwrites it.
                ptr              <= ptr_inc;
                entries[ptr_inc] <= bus.call_link;
                if (!full) begin
                    count <= count + 1'b1;
                end
            end else if (pop) begin
                ptr   <= ptr_dec;
                count <= count - 1'b1;
            end
        end
    end

    assign bus.pc_result    = {pc, 2'b00};
    assign bus.pc_plus4     = {pc + 1'b1, 2'b00};
    assign bus.ras_top      = empty ? '0 : {entries[ptr], 2'b00};
    assign bus.ras_empty    = empty;
    assign bus.ras_full     = full;
    assign bus.ret_miss     = ret_miss_q;
    assign bus.ras_overflow = overflow_q;
endmodule
